// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential radix-2 Booth multiplier:
//   - state_t     : controller state encoding (IDLE / RUN / DONE)
//   - BOOTH_*     : Booth recoding operations (no-op, add, subtract)
//   - cnt_width() : width of a counter that must hold values 0..steps
//   - booth_op()  : recodes the {Q[0], q_-1} pair into a Booth operation
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_NOP = 2'd0;
    localparam logic [1:0] BOOTH_ADD = 2'd1;
    localparam logic [1:0] BOOTH_SUB = 2'd2;

    // Counter must reach the value 'steps' after the last increment.
    function automatic int cnt_width(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

    // 01 -> end of a run of ones: add; 10 -> start of a run: subtract.
    function automatic logic [1:0] booth_op(input logic q0, input logic qm1);
        logic [1:0] op;
        case ({q0, qm1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator, then arithmetic right shift of
// {A, Q, q_-1} by one bit.
// Ports:
//   acc         in  AW  accumulator A
//   mcand       in  AW  multiplicand M (already extended to AW bits)
//   mplier      in  QW  multiplier register Q
//   qm1         in  1   Booth bit q_-1
//   acc_next    out AW  A after add/sub and shift
//   mplier_next out QW  Q after shift
//   qm1_next    out 1   q_-1 after shift
// -----------------------------------------------------------------------------
module booth_step
    import mult_pkg::*;
#(
    parameter int AW = 9,
    parameter int QW = 8
) (
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] mcand,
    input  logic [QW-1:0] mplier,
    input  logic          qm1,
    output logic [AW-1:0] acc_next,
    output logic [QW-1:0] mplier_next,
    output logic          qm1_next
);

    logic [AW-1:0] sum_s;

    // Booth add/subtract selected by the current {Q[0], q_-1} pair
    always_comb begin
        sum_s = acc;
        case (booth_op(mplier[0], qm1))
            BOOTH_ADD: sum_s = acc + mcand;
            BOOTH_SUB: sum_s = acc - mcand;
            default:   sum_s = acc;
        endcase
    end

    // Arithmetic right shift of {sum, Q, q_-1}; the sign of A is replicated
    always_comb begin
        acc_next    = {sum_s[AW-1], sum_s[AW-1:1]};
        mplier_next = {sum_s[0], mplier[QW-1:1]};
        qm1_next    = mplier[0];
    end

endmodule

// File: rtl/seq_booth_mult.sv
// -----------------------------------------------------------------------------
// seq_booth_mult
// Sequential signed multiplier, radix-2 Booth, one partial-product step per
// clock, with a start/busy/done handshake.
// Optional build macro: MULT_UNSIGNED_SEL_EN
//   defined   : adds input tc; tc=1 signed, tc=0 unsigned operands; both modes
//               take WIDTH+1 steps (operands extended to WIDTH+1 bits).
//   undefined : signed only, WIDTH steps.
// Ports:
//   clk    in  1        rising-edge clock
//   rst_n  in  1        asynchronous active-low reset
//   start  in  1        request, sampled only in IDLE
//   a      in  WIDTH    multiplicand, captured at accept
//   b      in  WIDTH    multiplier, captured at accept
//   tc     in  1        (macro only) 1 = signed, 0 = unsigned, captured at accept
//   busy   out 1        high in RUN and DONE
//   done   out 1        one-cycle pulse, product valid
//   p      out 2*WIDTH  product, held until the next completion
// -----------------------------------------------------------------------------
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_UNSIGNED_SEL_EN
    input  logic               tc,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

`ifdef MULT_UNSIGNED_SEL_EN
    // Q carries an extra extension bit so unsigned operands stay positive.
    localparam int QW = WIDTH + 1;
`else
    localparam int QW = WIDTH;
`endif
    // One guard bit on A keeps A-M exact for the most negative multiplicand.
    localparam int AW    = WIDTH + 1;
    localparam int STEPS = QW;
    localparam int CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [AW-1:0]    acc_r;
    logic [AW-1:0]    mcand_r;
    logic [QW-1:0]    mplier_r;
    logic             qm1_r;
    logic [CNT_W-1:0] cnt_r;

    logic [AW-1:0]      m_ext_s;
    logic [QW-1:0]      q_ext_s;
    logic [AW-1:0]      acc_nx_s;
    logic [QW-1:0]      q_nx_s;
    logic               qm1_nx_s;
    logic [2*WIDTH-1:0] p_nx_s;

    // Operand extension applied at the accept edge
    always_comb begin
`ifdef MULT_UNSIGNED_SEL_EN
        if (tc) begin
            m_ext_s = {a[WIDTH-1], a};
            q_ext_s = {b[WIDTH-1], b};
        end else begin
            m_ext_s = {1'b0, a};
            q_ext_s = {1'b0, b};
        end
`else
        m_ext_s = {a[WIDTH-1], a};
        q_ext_s = b;
`endif
    end

    booth_step #(
        .AW (AW),
        .QW (QW)
    ) u_step (
        .acc         (acc_r),
        .mcand       (mcand_r),
        .mplier      (mplier_r),
        .qm1         (qm1_r),
        .acc_next    (acc_nx_s),
        .mplier_next (q_nx_s),
        .qm1_next    (qm1_nx_s)
    );

    // Product as it stands after the current step: low 2*WIDTH bits of {A,Q}
    always_comb begin
`ifdef MULT_UNSIGNED_SEL_EN
        p_nx_s = {acc_nx_s[WIDTH-2:0], q_nx_s};
`else
        p_nx_s = {acc_nx_s[WIDTH-1:0], q_nx_s};
`endif
    end

    // Controller FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            acc_r    <= {AW{1'b0}};
            mcand_r  <= {AW{1'b0}};
            mplier_r <= {QW{1'b0}};
            qm1_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            p        <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_r  <= m_ext_s;
                        acc_r    <= {AW{1'b0}};
                        mplier_r <= q_ext_s;
                        qm1_r    <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r    <= acc_nx_s;
                    mplier_r <= q_nx_s;
                    qm1_r    <= qm1_nx_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    // p is written only on the step that completes the product
                    if (cnt_r == LAST_CNT) begin
                        p       <= p_nx_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_booth_mult
// Scoreboard bench for seq_booth_mult at WIDTH=8. The driver pushes the
// hand-computed product for every operand pair it presents; a handshake model
// decides which presentations are accepted and queues their products; the
// monitor pops on every done pulse and checks busy/done/p each cycle.
// -----------------------------------------------------------------------------
module tb_seq_booth_mult;

    localparam int WIDTH = 8;
`ifdef MULT_UNSIGNED_SEL_EN
    localparam int LAT = WIDTH + 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a     = 8'd0;
    logic [7:0]  b     = 8'd0;
    logic        tc    = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] p;

    logic [15:0] exp_hand = 16'd0;
    logic        snap_start = 1'b0;
    logic [15:0] snap_exp = 16'd0;
    logic [15:0] sb_q[$];
    logic [15:0] held_p = 16'd0;
    int          mcnt = 0;
    int          tests = 0;
    int          fails = 0;

    logic [7:0]  rot_a [7];
    logic [7:0]  rot_b [7];
    logic [15:0] rot_p [7];

    seq_booth_mult #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef MULT_UNSIGNED_SEL_EN
        .tc    (tc),
`endif
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs as the DUT saw them at each rising edge
    always @(posedge clk) begin
        snap_start <= start & rst_n;
        snap_exp   <= exp_hand;
    end

    // Handshake model plus monitor, evaluated between edges
    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt   = 0;
            sb_q.delete();
            held_p = 16'd0;
        end else if (mcnt == 0) begin
            if (snap_start) begin
                sb_q.push_back(snap_exp);
                mcnt = LAT + 1;
            end
        end else begin
            mcnt = mcnt - 1;
        end

        chk("busy", {31'd0, busy}, (mcnt > 0) ? 32'd1 : 32'd0);
        chk("done", {31'd0, done}, (mcnt == 1) ? 32'd1 : 32'd0);
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("done_without_request", 32'd1, 32'd0);
            end else begin
                held_p = sb_q.pop_front();
                chk("product", {16'd0, p}, {16'd0, held_p});
            end
        end else begin
            chk("p_hold", {16'd0, p}, {16'd0, held_p});
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && mcnt != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (mcnt != 0) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic vtc, input logic [15:0] vp);
        wait_idle();
        a        = va;
        b        = vb;
        tc       = vtc;
        exp_hand = vp;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start    = 1'b0;
        a        = ~va;
        b        = ~vb;
    endtask

    initial begin
        rot_a[0] = 8'd3;   rot_b[0] = 8'd5;   rot_p[0] = 16'h000F;
        rot_a[1] = 8'hF9;  rot_b[1] = 8'd6;   rot_p[1] = 16'hFFD6;
        rot_a[2] = 8'h80;  rot_b[2] = 8'h80;  rot_p[2] = 16'h4000;
        rot_a[3] = 8'd12;  rot_b[3] = 8'hF4;  rot_p[3] = 16'hFF70;
        rot_a[4] = 8'd127; rot_b[4] = 8'd127; rot_p[4] = 16'h3F01;
        rot_a[5] = 8'h9C;  rot_b[5] = 8'd50;  rot_p[5] = 16'hEC78;
        rot_a[6] = 8'd25;  rot_b[6] = 8'd25;  rot_p[6] = 16'h0271;

        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Directed signed vectors
        run_op(8'd3,   8'd5,   1'b1, 16'h000F);
        run_op(8'hF9,  8'd6,   1'b1, 16'hFFD6);
        run_op(8'h80,  8'h80,  1'b1, 16'h4000);
        run_op(8'h80,  8'd127, 1'b1, 16'hC080);
        run_op(8'd127, 8'h80,  1'b1, 16'hC080);
        run_op(8'd0,   8'h80,  1'b1, 16'h0000);
        run_op(8'hFF,  8'hFF,  1'b1, 16'h0001);
        run_op(8'hFF,  8'd127, 1'b1, 16'hFF81);
        run_op(8'd1,   8'hFF,  1'b1, 16'hFFFF);
        run_op(8'd127, 8'd127, 1'b1, 16'h3F01);

        // Start held high with operands changing every cycle
        wait_idle();
        for (int i = 0; i < 30; i++) begin
            start    = 1'b1;
            a        = rot_a[i % 7];
            b        = rot_b[i % 7];
            exp_hand = rot_p[i % 7];
            @(negedge clk);
            #1;
        end
        start = 1'b0;

        // Reset in the middle of a run, after the fourth Booth step
        run_op(8'd5, 8'd7, 1'b1, 16'h0023);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_op(8'd2, 8'hFD, 1'b1, 16'hFFFA);

`ifdef MULT_UNSIGNED_SEL_EN
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op(8'hFF, 8'hFF, 1'b1, 16'h0001);
        run_op(8'h80, 8'h80, 1'b0, 16'h4000);
        run_op(8'hC8, 8'd3,  1'b0, 16'h0258);
`endif

        wait_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drain", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
